// File: rtl/axi4_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the write master and its slave.
// Master drives the address/data/response-ready side; slave drives the readies and response.
interface axi4_write_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/axi4_write_master.sv
// Single-outstanding AXI4 INCR write-burst master: accepts a (addr, len) command,
// streams in_data beats onto W, and reports the B response (or a 4KB-crossing error) on done.
module axi4_write_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,

  output logic                  done,
  output logic [1:0]            done_resp,

  axi4_write_master_if.master   m_axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [7:0]            len_q,   len_d;
  logic [7:0]            cnt_q,   cnt_d;
  logic                  live_q,  live_d;

  logic                  cmd_ready_c;
  logic                  in_ready_c;
  logic                  done_c;
  logic [1:0]            done_resp_c;
  logic                  aw_valid_c;
  logic                  w_valid_c;
  logic                  w_last_c;
  logic                  b_ready_c;
  logic                  beat_c;

  // True when a burst of (len+1) beats starting at addr runs past the end of its 4KB page.
  function automatic logic crosses_4k(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [7:0]            len);
    logic [ADDR_WIDTH+11:0] ext;
    logic [13:0]            span;
    logic [13:0]            end_off;
    ext     = {12'd0, addr};
    span    = ({6'd0, len} + 14'd1) << SIZE;
    end_off = {2'b00, ext[11:0]} + span;
    return end_off > 14'd4096;
  endfunction

  // Control registers; async reset lands every one of them in a quiet IDLE.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    live_d      = 1'b1;

    // live_q keeps cmd_ready low until the first edge after reset release.
    cmd_ready_c = (state_q == IDLE) && live_q;
    aw_valid_c  = (state_q == ADDR);
    w_valid_c   = (state_q == DATA) && in_valid;
    w_last_c    = (state_q == DATA) && (cnt_q == len_q);
    in_ready_c  = (state_q == DATA) && m_axi.WREADY;
    b_ready_c   = (state_q == RESP);
    beat_c      = w_valid_c && m_axi.WREADY;
    done_c      = 1'b0;
    done_resp_c = 2'b00;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_c) begin
          addr_d  = cmd_addr & ALIGN_MASK;
          len_d   = cmd_len;
          state_d = crosses_4k(cmd_addr & ALIGN_MASK, cmd_len) ? ERR : ADDR;
        end
      end
      ADDR: begin
        if (m_axi.AWREADY) begin
          state_d = DATA;
          cnt_d   = 8'd0;
        end
      end
      DATA: begin
        if (beat_c) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (m_axi.BVALID) begin
          done_c      = 1'b1;
          done_resp_c = m_axi.BRESP;
          state_d     = IDLE;
        end
      end
      ERR: begin
        done_c      = 1'b1;
        done_resp_c = RESP_SLVERR;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready     = cmd_ready_c;
  assign in_ready      = in_ready_c;
  assign done          = done_c;
  assign done_resp     = done_resp_c;

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWLEN   = len_q;
  assign m_axi.AWSIZE  = 3'(SIZE);
  assign m_axi.AWBURST = BURST_INCR;
  assign m_axi.AWVALID = aw_valid_c;
  assign m_axi.WDATA   = in_data;
  assign m_axi.WVALID  = w_valid_c;
  assign m_axi.WLAST   = w_last_c;
  assign m_axi.BREADY  = b_ready_c;

endmodule

// File: tb/tb_axi4_write_master.sv
// Directed bench for axi4_write_master: hand-scripted slave handshakes with
// expected values worked out per cycle.
module tb_axi4_write_master;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          ACLK      = 1'b0;
  logic          ARESETn   = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr  = '0;
  logic [7:0]    cmd_len   = '0;
  logic [DW-1:0] in_data   = '0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic          done;
  logic [1:0]    done_resp;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_write_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .done      (done),
    .done_resp (done_resp),
    .m_axi     (axi)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full burst with an always-ready slave; checks address, WLAST placement and response.
  task automatic burst(input logic [15:0] addr, input logic [15:0] exp_addr,
                       input logic [7:0] len, input logic [1:0] resp);
    cmd_addr     = addr;
    cmd_len      = len;
    cmd_valid    = 1'b1;
    axi.AWREADY  = 1'b1;
    axi.WREADY   = 1'b1;
    axi.BVALID   = 1'b0;
    in_valid     = 1'b1;
    #1;
    check("bu_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    #1;
    check("bu_awvalid", 64'(axi.AWVALID), 64'(1));
    check("bu_awaddr", 64'(axi.AWADDR), 64'(exp_addr));
    check("bu_awlen", 64'(axi.AWLEN), 64'(len));
    tick();
    for (int b = 0; b <= int'(len); b++) begin
      in_data = 32'hB0 + 32'(b);
      #1;
      check("bu_wvalid", 64'(axi.WVALID), 64'(1));
      check("bu_wlast", 64'(axi.WLAST), 64'(b == int'(len)));
      tick();
    end
    in_valid   = 1'b0;
    axi.BVALID = 1'b1;
    axi.BRESP  = resp;
    #1;
    check("bu_bready", 64'(axi.BREADY), 64'(1));
    check("bu_done", 64'(done), 64'(1));
    check("bu_done_resp", 64'(done_resp), 64'(resp));
    tick();
    axi.BVALID = 1'b0;
    #1;
    check("bu_done_clear", 64'(done), 64'(0));
    check("bu_ready_again", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pv;
    logic [19:0] pr;
    int          k;

    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;

    // Reset state
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_awvalid", 64'(axi.AWVALID), 64'(0));
    check("rst_wvalid", 64'(axi.WVALID), 64'(0));
    check("rst_bready", 64'(axi.BREADY), 64'(0));
    check("rst_wlast", 64'(axi.WLAST), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_awaddr", 64'(axi.AWADDR), 64'(0));
    check("rst_awlen", 64'(axi.AWLEN), 64'(0));
    check("rst_done_resp", 64'(done_resp), 64'(0));
    tick();
    check("rst_hold_cmd_ready", 64'(cmd_ready), 64'(0));
    #2;
    ARESETn = 1'b1;
    tick();
    check("rel_cmd_ready", 64'(cmd_ready), 64'(1));
    check("awsize", 64'(axi.AWSIZE), 64'(2));
    check("awburst", 64'(axi.AWBURST), 64'(1));

    // Single-beat burst, unaligned address, slave always ready
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    cmd_addr    = 16'h0012;
    cmd_len     = 8'd0;
    cmd_valid   = 1'b1;
    in_valid    = 1'b1;
    in_data     = 32'h11;
    #1;
    check("t1_wvalid_idle", 64'(axi.WVALID), 64'(0));
    tick();
    cmd_valid = 1'b0;
    #1;
    check("t1_awvalid", 64'(axi.AWVALID), 64'(1));
    check("t1_awaddr", 64'(axi.AWADDR), 64'(16'h0010));
    check("t1_awlen", 64'(axi.AWLEN), 64'(0));
    check("t1_awsize", 64'(axi.AWSIZE), 64'(2));
    check("t1_wvalid_addr", 64'(axi.WVALID), 64'(0));
    check("t1_in_ready_addr", 64'(in_ready), 64'(0));
    check("t1_cmd_ready_busy", 64'(cmd_ready), 64'(0));
    tick();
    check("t1_awvalid_off", 64'(axi.AWVALID), 64'(0));
    check("t1_wvalid", 64'(axi.WVALID), 64'(1));
    check("t1_wdata", 64'(axi.WDATA), 64'(32'h11));
    check("t1_wlast", 64'(axi.WLAST), 64'(1));
    check("t1_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("t1_bready", 64'(axi.BREADY), 64'(1));
    check("t1_wvalid_resp", 64'(axi.WVALID), 64'(0));
    check("t1_done_wait", 64'(done), 64'(0));
    in_valid   = 1'b0;
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b00;
    #1;
    check("t1_done", 64'(done), 64'(1));
    check("t1_done_resp", 64'(done_resp), 64'(0));
    tick();
    axi.BVALID = 1'b0;
    #1;
    check("t1_done_once", 64'(done), 64'(0));
    check("t1_cmd_ready_next", 64'(cmd_ready), 64'(1));

    // Four beats with in_valid / WREADY gaps, SLVERR response
    pv = 20'hFFFED;
    pr = 20'hFFFF6;
    cmd_addr  = 16'h0100;
    cmd_len   = 8'd3;
    cmd_valid = 1'b1;
    axi.WREADY = 1'b0;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("t2_awvalid", 64'(axi.AWVALID), 64'(1));
    tick();
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      in_valid   = pv[c];
      axi.WREADY = pr[c];
      in_data    = 32'hA0 + 32'(k);
      #1;
      check("t2_wvalid", 64'(axi.WVALID), 64'(pv[c]));
      check("t2_in_ready", 64'(in_ready), 64'(pr[c]));
      if (axi.WVALID && axi.WREADY) begin
        check("t2_wdata", 64'(axi.WDATA), 64'(32'hA0 + 32'(k)));
        check("t2_wlast", 64'(axi.WLAST), 64'(k == 3));
        k++;
      end else begin
        check("t2_wlast_idle", 64'(axi.WLAST), 64'(0));
      end
      tick();
    end
    check("t2_beats", 64'(k), 64'(4));
    in_valid = 1'b1;
    #1;
    check("t2_wvalid_resp", 64'(axi.WVALID), 64'(0));
    check("t2_bready", 64'(axi.BREADY), 64'(1));
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b10;
    #1;
    check("t2_done", 64'(done), 64'(1));
    check("t2_done_resp", 64'(done_resp), 64'(2'b10));
    tick();
    axi.BVALID = 1'b0;
    in_valid   = 1'b0;

    // AWREADY held low five cycles
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b1;
    in_valid    = 1'b1;
    cmd_addr    = 16'h0206;
    cmd_len     = 8'd1;
    cmd_valid   = 1'b1;
    #1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) axi.AWREADY = 1'b1;
      #1;
      check("t3_awvalid", 64'(axi.AWVALID), 64'(1));
      check("t3_awaddr", 64'(axi.AWADDR), 64'(16'h0204));
      check("t3_awlen", 64'(axi.AWLEN), 64'(1));
      check("t3_wvalid", 64'(axi.WVALID), 64'(0));
      tick();
    end
    in_data = 32'hC0;
    #1;
    check("t3_b0_wvalid", 64'(axi.WVALID), 64'(1));
    check("t3_b0_wlast", 64'(axi.WLAST), 64'(0));
    tick();
    in_data = 32'hC1;
    #1;
    check("t3_b1_wlast", 64'(axi.WLAST), 64'(1));
    tick();
    in_valid   = 1'b0;
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b00;
    #1;
    check("t3_done_resp", 64'(done_resp), 64'(0));
    tick();
    axi.BVALID = 1'b0;

    // 4KB crossing: 0x0FF8 + 16 bytes
    cmd_addr  = 16'h0FF8;
    cmd_len   = 8'd3;
    cmd_valid = 1'b1;
    #1;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("t4_awvalid", 64'(axi.AWVALID), 64'(0));
    check("t4_done", 64'(done), 64'(1));
    check("t4_done_resp", 64'(done_resp), 64'(2'b10));
    check("t4_cmd_ready_err", 64'(cmd_ready), 64'(0));
    tick();
    check("t4_done_once", 64'(done), 64'(0));
    check("t4_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t4_awvalid_idle", 64'(axi.AWVALID), 64'(0));

    // Reset two beats into an eight-beat burst
    cmd_addr    = 16'h0400;
    cmd_len     = 8'd7;
    cmd_valid   = 1'b1;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    in_valid    = 1'b1;
    #1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int b = 0; b < 2; b++) begin
      in_data = 32'hD0 + 32'(b);
      #1;
      check("t5_wvalid", 64'(axi.WVALID), 64'(1));
      check("t5_wlast", 64'(axi.WLAST), 64'(0));
      tick();
    end
    ARESETn = 1'b0;
    #1;
    check("t5_rst_awvalid", 64'(axi.AWVALID), 64'(0));
    check("t5_rst_wvalid", 64'(axi.WVALID), 64'(0));
    check("t5_rst_bready", 64'(axi.BREADY), 64'(0));
    check("t5_rst_in_ready", 64'(in_ready), 64'(0));
    check("t5_rst_done", 64'(done), 64'(0));
    check("t5_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("t5_rst_awlen", 64'(axi.AWLEN), 64'(0));
    tick();
    ARESETn  = 1'b1;
    in_valid = 1'b0;
    tick();
    check("t5_rel_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t5_rel_done", 64'(done), 64'(0));
    check("t5_rel_awvalid", 64'(axi.AWVALID), 64'(0));

    // Exactly filling a page (0x0FF3 aligns to 0x0FF0, ends at 4096) is legal
    burst(16'h0FF3, 16'h0FF0, 8'd3, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_write_master.md
AXI4_WRITE_MASTER -- requirements
Module: axi4_write_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning W channel / input data width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning AWADDR and cmd_addr width in bits.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning:
- ACLK  in  1  single clock, rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  burst start byte address
- cmd_len  in  8  beats minus one
- in_data  in  DATA_WIDTH  write beat data
- in_valid  in  1  in_data valid
- in_ready  out  1  in_data consumed when high with in_valid
- done  out  1  one-cycle completion pulse
- done_resp  out  2  response for the completed command, valid with done
- AWADDR  out  ADDR_WIDTH  AXI write address
- AWLEN  out  8  AXI burst length
- AWSIZE  out  3  AXI beat size
- AWVALID  out  1  AXI address valid
- AWREADY  in  1  AXI address ready
- WDATA  out  DATA_WIDTH  AXI write data
- WLAST  out  1  AXI last beat
- WVALID  out  1  AXI data valid
- WREADY  in  1  AXI data ready
- BRESP  in  2  AXI write response
- BVALID  in  1  AXI response valid
- BREADY  out  1  AXI response ready

Function
REQ-004 SHALL implement an FSM with states IDLE, ADDR, DATA, RESP and ERR; the burst type SHALL always be INCR.
REQ-005 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL register cmd_addr, with its low log2(DATA_WIDTH/8) bits forced to 0, and cmd_len.
REQ-006 4KB check at acceptance: if addr[11:0] + (cmd_len+1)*(DATA_WIDTH/8) > 4096, go to ERR; otherwise go to ADDR.
REQ-007 ERR: no AXI activity; done=1 and done_resp=2'b10 for exactly one cycle; then IDLE.
REQ-008 ADDR: AWVALID=1 starting the cycle after acceptance; AWADDR, AWLEN and AWSIZE held stable until the AWVALID&AWREADY handshake; then DATA.
REQ-009 AWSIZE SHALL equal log2(DATA_WIDTH/8) (2 for 32-bit) and SHALL be constant.
REQ-010 WVALID SHALL be 0 in every state except DATA; no W beat SHALL precede the AW handshake.
REQ-011 DATA: WDATA=in_data, WVALID=in_valid, in_ready=WREADY (combinational); a beat completes on WVALID&WREADY.
REQ-012 An 8-bit beat counter SHALL reset to 0 on entering DATA and increment per completed beat.
REQ-013 WLAST=1 iff in DATA and counter==AWLEN; cmd_len=0 gives WLAST on the first beat.
REQ-014 After the beat with WLAST, the FSM SHALL go to RESP; in_ready SHALL be 0 outside DATA.
REQ-015 RESP: BREADY=1; on BVALID, done=1 and done_resp=BRESP for one cycle; then IDLE.
REQ-016 cmd_ready SHALL be 0 in all states except IDLE.
REQ-017 A new command SHALL be acceptable the cycle after done; throughput is one outstanding burst.
REQ-018 Once asserted, WVALID and AWVALID SHALL be driven from registered state so they are never withdrawn before their handshake; a WVALID drop is solely the upstream in_valid's responsibility.

Reset
REQ-019 ARESETn low SHALL asynchronously force IDLE, counter 0, AWVALID/WVALID/BREADY/WLAST/done/in_ready=0, AWADDR/AWLEN/done_resp=0, and cmd_ready=0 while reset is asserted.
REQ-020 Reset mid-burst SHALL abandon the burst with no done pulse; cmd_ready=1 from the first clock edge after release.

Verification
REQ-021 cmd_addr=0x0012, cmd_len=0, slave always ready -> AWADDR=0x0010, AWLEN=0, AWSIZE=2 on the cycle after acceptance; one W beat with WLAST=1; BRESP=00 -> done pulse, done_resp=00.
REQ-022 cmd_len=3, random WREADY/in_valid gaps, data 0xA0..0xA3 -> exactly 4 W handshakes in order; WLAST only on 0xA3.
REQ-023 AWREADY held low 5 cycles -> AWVALID and AWADDR stable for 6 cycles; WVALID=0 throughout.
REQ-024 cmd_addr=0x0FF8, cmd_len=3 (16B crosses 4KB) -> no AWVALID; done with done_resp=10 the cycle after acceptance.
REQ-025 Slave returns BRESP=10 -> done_resp=10; ARESETn pulsed after 2 of 8 beats -> all AXI valids 0 immediately, no done, next command accepted normally.
